// File: rtl/spi_frame_tx_if.sv
// spi_frame_tx_if: bundles the sample push handshake, the SPI pins and the
// status outputs of spi_frame_tx. The design uses the slave modport and the
// environment (audio pipeline, MCU model, bench) uses the master modport.
//
// Handshake: a frame on sample_in is accepted on a clk rising edge where
// sample_valid and sample_ready are both high. sample_ready depends only on
// the FIFO fill state, never on sample_valid. When sample_valid is high while
// sample_ready is low, the frame is dropped and the overflow flag is raised.
// There is no back-pressure retry.
interface spi_frame_tx_if #(
   parameter int DATA_W     = 16,
   parameter int CHANNELS   = 2,
   parameter int FIFO_DEPTH = 8
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_W*CHANNELS-1:0] sample_in;
   logic                       sample_valid;
   logic                       sample_ready;
   logic                       clear_flags;
   logic                       sck;
   logic                       cs_n;
   logic                       sdo;
   logic [LVL_W-1:0]           fifo_level;
   logic                       underflow;
   logic                       overflow;
   // FSM state for observation: 0 = IDLE, 1 = SHIFT, 2 = DONE
   logic [1:0]                 fsm_state;

   modport slave (
      input  sample_in,
      input  sample_valid,
      input  clear_flags,
      input  sck,
      input  cs_n,
      output sample_ready,
      output sdo,
      output fifo_level,
      output underflow,
      output overflow,
      output fsm_state
   );

   modport master (
      output sample_in,
      output sample_valid,
      output clear_flags,
      output sck,
      output cs_n,
      input  sample_ready,
      input  sdo,
      input  fifo_level,
      input  underflow,
      input  overflow,
      input  fsm_state
   );
endinterface

// File: rtl/spi_frame_tx.sv
// spi_frame_tx: buffers multi-channel PCM frames in a FIFO and serves them to
// an MCU as an SPI mode-0 target. sck and cs_n are oversampled in clk, which
// must run at least 8x the sck frequency.
//
// Optional feature macro: SPI_SEQ_HEADER_EN. When it is defined, every frame
// is prefixed by an 8-bit header: {underflow_frame, seq[6:0]}.
module spi_frame_tx #(
   parameter int DATA_W      = 16,
   parameter int CHANNELS    = 2,
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input logic          clk,
   input logic          reset,
   spi_frame_tx_if.slave bus
);

   localparam int PAYLOAD_W = DATA_W * CHANNELS;
`ifdef SPI_SEQ_HEADER_EN
   localparam int FRAME_BITS = 8 + PAYLOAD_W;
`else
   localparam int FRAME_BITS = PAYLOAD_W;
`endif
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LVL_W = AW + 1;
   localparam int CNT_W = $clog2(FRAME_BITS + 1);

   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // sck / cs_n synchronisers and edge detectors
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic                   sck_prev_q;
   logic                   cs_prev_q;
   logic                   sck_s;
   logic                   cs_s;
   logic                   sck_rise;
   logic                   sck_fall;
   logic                   cs_fall;
   logic                   cs_rise;

   // Shift the asynchronous pins through the synchroniser chains. cs_n resets
   // high (deselected) so that leaving reset cannot produce a false cs_fall.
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync_q <= '0;
         cs_sync_q  <= '1;
         sck_prev_q <= 1'b0;
         cs_prev_q  <= 1'b1;
      end else begin
         sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
         cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
         sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
         cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
      end
   end

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign cs_fall  = ~cs_s & cs_prev_q;
   assign cs_rise  = cs_s & ~cs_prev_q;

   // ------------------------------------------------------------------
   // Frame FIFO
   // ------------------------------------------------------------------
   logic [PAYLOAD_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     level_q, level_d;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic                 load_frame;

   assign full  = (level_q == FULL_LVL);
   assign empty = (level_q == '0);
   // A full FIFO refuses the push even when a pop frees a slot this cycle.
   assign push  = bus.sample_valid & ~full;
   assign pop   = load_frame & ~empty;

   // Storage has no reset; the pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.sample_in;
      end
   end

   // Next pointer and fill level from the push/pop pair.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // FIFO pointer and level registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // ------------------------------------------------------------------
   // Frame assembly: channel 0 goes out first, so it is moved to the top
   // of the shift word. An empty FIFO yields an all-zero frame.
   // ------------------------------------------------------------------
   logic [PAYLOAD_W-1:0]  head_frame;
   logic [PAYLOAD_W-1:0]  payload_ord;
   logic [FRAME_BITS-1:0] load_word;

   assign head_frame = mem_q[rd_ptr_q];

   // Reorder the head frame so channel 0 lands in the MSBs.
   always_comb begin
      payload_ord = '0;
      if (!empty) begin
         for (int k = 0; k < CHANNELS; k++) begin
            payload_ord[(CHANNELS-1-k)*DATA_W +: DATA_W] = head_frame[k*DATA_W +: DATA_W];
         end
      end
   end

`ifdef SPI_SEQ_HEADER_EN
   logic [6:0] seq_q, seq_d;

   assign load_word = {empty, seq_q, payload_ord};
   assign seq_d     = load_frame ? seq_q + 7'd1 : seq_q;

   // Sequence counter advances on every frame load, underflow frames included.
   always_ff @(posedge clk) begin
      if (reset) begin
         seq_q <= '0;
      end else begin
         seq_q <= seq_d;
      end
   end
`else
   assign load_word = payload_ord;
`endif

   // ------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------
   state_t                state_q, state_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;

   // Next state, shift register and bit counter. cs_fall is only honoured in
   // IDLE, so chip-select glitches during a frame are ignored.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      load_frame = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               load_frame = 1'b1;
               shift_d    = load_word;
               bit_cnt_d  = '0;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               // Aborted frame: the popped frame is discarded.
               state_d = ST_IDLE;
            end else begin
               if (sck_rise) begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == LAST_BIT) begin
                     state_d = ST_DONE;
                  end
               end
               if (sck_fall) begin
                  shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
               end
            end
         end
         ST_DONE: begin
            if (cs_rise) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state, shift register and bit counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Sticky flags: a set event beats a simultaneous clear.
   // ------------------------------------------------------------------
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   assign overflow_d  = (bus.sample_valid & full) | (overflow_q & ~bus.clear_flags);
   assign underflow_d = (load_frame & empty) | (underflow_q & ~bus.clear_flags);

   // Flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.sample_ready = ~full;
   assign bus.sdo          = (state_q == ST_SHIFT) ? shift_q[FRAME_BITS-1] : 1'b0;
   assign bus.fifo_level   = level_q;
   assign bus.underflow    = underflow_q;
   assign bus.overflow     = overflow_q;
   assign bus.fsm_state    = state_q;

endmodule
